// File: rtl/lpddr2_pkg.sv
// rtl/lpddr2_pkg.sv - shared types and constants for the LPDDR2 CPU-port responder
package lpddr2_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RDW,
    ST_DONE
  } state_e;

  localparam int DEF_ADDR_W  = 27;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 1023;

  // Returned to the CPU when the controller never answers.
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/lpddr2_hit_reg.sv
// rtl/lpddr2_hit_reg.sv - one-entry read-hit register with fill, write-through and invalidate
module lpddr2_hit_reg import lpddr2_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  input  logic              fill_en_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              wt_en_i,
  input  logic [ADDR_W-1:0] wt_addr_i,
  input  logic [DATA_W-1:0] wt_data_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] hit_data_o
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  // Fill on a completed read; a write to the cached word refreshes its data so later hits stay coherent.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (fill_en_i) begin
      valid_q <= 1'b1;
      addr_q  <= fill_addr_i;
      data_q  <= fill_data_i;
    end else if (wt_en_i && valid_q && (wt_addr_i == addr_q)) begin
      data_q  <= wt_data_i;
    end
  end

  assign hit_o      = valid_q && (lookup_addr_i == addr_q);
  assign hit_data_o = data_q;

endmodule

// File: rtl/lpddr2_responder.sv
// rtl/lpddr2_responder.sv - CPU memory port to single-beat Avalon-MM LPDDR2 bridge with stall
module lpddr2_responder import lpddr2_pkg::*; #(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   write_data,
  input  logic                read_req,
  input  logic                write_req,
  output logic [DATA_W-1:0]   read_data,
  output logic                stall,
  output logic                err,
  input  logic                avl_ready,
  output logic [ADDR_W-1:0]   avl_address,
  output logic [DATA_W-1:0]   avl_writedata,
  output logic [DATA_W/8-1:0] avl_byteenable,
  output logic                avl_burstcount,
  output logic                avl_read,
  output logic                avl_write,
  input  logic                avl_waitrequest,
  input  logic [DATA_W-1:0]   avl_readdata,
  input  logic                avl_readdatavalid
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              err_q, avl_read_q, avl_write_q;
  logic              hit;
  logic [DATA_W-1:0] hit_data;

  logic in_xfer, timeout, wr_accept, rd_accept, rd_capture, to_err;
  logic start_wr, start_rd;

  assign in_xfer    = (state_q == ST_WR) || (state_q == ST_RD) || (state_q == ST_RDW);
  // The counter starts at 0 on entry, so this fires on the TIMEOUT-th cycle spent waiting.
  assign timeout    = in_xfer && (cnt_q == CNT_LAST);
  assign wr_accept  = (state_q == ST_WR) && !avl_waitrequest;
  assign rd_accept  = (state_q == ST_RD) && !avl_waitrequest;
  assign rd_capture = avl_readdatavalid && ((state_q == ST_RDW) || rd_accept);
  // A real completion on the last allowed cycle beats the timeout.
  assign to_err     = timeout && !wr_accept && !rd_capture;
  assign start_wr   = (state_q == ST_IDLE) && write_req;
  assign start_rd   = (state_q == ST_IDLE) && !write_req && read_req && !hit;

  lpddr2_hit_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_hit (
    .clk_i         (clk),
    .rst_i         (rst),
    .lookup_addr_i (address),
    .fill_en_i     (rd_capture),
    .fill_addr_i   (addr_q),
    .fill_data_i   (avl_readdata),
    .wt_en_i       (wr_accept),
    .wt_addr_i     (addr_q),
    .wt_data_i     (wdata_q),
    .hit_o         (hit),
    .hit_data_o    (hit_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (avl_ready) state_d = ST_IDLE;
      ST_IDLE: begin
        if (start_wr)      state_d = ST_WR;
        else if (start_rd) state_d = ST_RD;
      end
      ST_WR:   if (wr_accept || timeout) state_d = ST_DONE;
      ST_RD: begin
        if (rd_capture || timeout) state_d = ST_DONE;
        else if (rd_accept)        state_d = ST_RDW;
      end
      ST_RDW:  if (rd_capture || timeout) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  // CPU-facing outputs: stall everywhere except DONE and an idle cycle with nothing to fetch.
  always_comb begin
    stall     = !((state_q == ST_DONE) || ((state_q == ST_IDLE) && !start_wr && !start_rd));
    read_data = ((state_q == ST_IDLE) && hit) ? hit_data : rdata_q;
  end

  // Datapath: request latch, timeout counter, registered Avalon strobes and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      avl_read_q  <= 1'b0;
      avl_write_q <= 1'b0;
    end else begin
      avl_read_q  <= (state_d == ST_RD);
      avl_write_q <= (state_d == ST_WR);
      if (start_wr || start_rd) begin
        cnt_q  <= '0;
        addr_q <= address;
      end else if (in_xfer) begin
        cnt_q  <= cnt_q + 1'b1;
      end
      if (start_wr) wdata_q <= write_data;
      if (rd_capture) begin
        rdata_q <= avl_readdata;
      end else if (to_err) begin
        rdata_q <= DATA_W'(ERR_DATA);
        err_q   <= 1'b1;
      end
    end
  end

  assign err            = err_q;
  assign avl_read       = avl_read_q;
  assign avl_write      = avl_write_q;
  assign avl_address    = addr_q;
  assign avl_writedata  = wdata_q;
  assign avl_byteenable = '1;
  assign avl_burstcount = 1'b1;

endmodule

// File: tb/tb_lpddr2_responder.sv
// tb/tb_lpddr2_responder.sv - directed vector bench for lpddr2_responder
module tb_lpddr2_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [26:0] address;
  logic [31:0] write_data;
  logic        read_req, write_req;
  logic [31:0] read_data;
  logic        stall, err;
  logic        avl_ready;
  logic [26:0] avl_address;
  logic [31:0] avl_writedata;
  logic [3:0]  avl_byteenable;
  logic        avl_burstcount;
  logic        avl_read, avl_write;
  logic        avl_waitrequest;
  logic [31:0] avl_readdata;
  logic        avl_readdatavalid;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lpddr2_responder #(.ADDR_W(27), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk               (clk),
    .rst               (rst),
    .address           (address),
    .write_data        (write_data),
    .read_req          (read_req),
    .write_req         (write_req),
    .read_data         (read_data),
    .stall             (stall),
    .err               (err),
    .avl_ready         (avl_ready),
    .avl_address       (avl_address),
    .avl_writedata     (avl_writedata),
    .avl_byteenable    (avl_byteenable),
    .avl_burstcount    (avl_burstcount),
    .avl_read          (avl_read),
    .avl_write         (avl_write),
    .avl_waitrequest   (avl_waitrequest),
    .avl_readdata      (avl_readdata),
    .avl_readdatavalid (avl_readdatavalid)
  );

  typedef struct {
    logic        ready, rd, wr;
    logic [26:0] addr;
    logic [31:0] wdata;
    logic        wreq, rdv;
    logic [31:0] rdin;
    logic        stall, aread, awrite;
    logic [31:0] rdata;
    logic [26:0] aaddr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic ready, rd, wr, input logic [26:0] addr,
                              input logic [31:0] wdata, input logic wreq, rdv,
                              input logic [31:0] rdin, input logic e_stall, e_aread, e_awrite,
                              input logic [31:0] e_rdata, input logic [26:0] e_aaddr);
    vec_t v;
    v.ready = ready; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.wreq = wreq; v.rdv = rdv; v.rdin = rdin;
    v.stall = e_stall; v.aread = e_aread; v.awrite = e_awrite;
    v.rdata = e_rdata; v.aaddr = e_aaddr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; address = '0; write_data = '0; read_req = 1'b0; write_req = 1'b0;
    avl_ready = 1'b0; avl_waitrequest = 1'b1; avl_readdata = '0; avl_readdatavalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_stall", {31'd0, stall}, 32'd1);
    chk("reset_strobes", {30'd0, avl_read, avl_write}, 32'd0);
    chk("reset_read_data", read_data, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("byteenable", {28'd0, avl_byteenable}, 32'hF);
    chk("burstcount", {31'd0, avl_burstcount}, 32'd1);

    // Calibration wait, then idle.
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0,0,0,0,0,1,0,0, 1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,1,0,0, 1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,1,0,0, 0,0,0,0,0));
    // Write 0x800 with waitrequest high for three cycles.
    tbl.push_back(mk(1,0,1,27'h800,32'h1234_5678,1,0,0, 1,0,0,0,0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,1,27'h800,32'h1234_5678,1,0,0, 1,0,1,0,27'h800));
    tbl.push_back(mk(1,0,1,27'h800,32'h1234_5678,0,0,0, 1,0,1,0,27'h800));
    tbl.push_back(mk(1,0,0,27'h800,0,1,0,0, 0,0,0,0,27'h800));
    tbl.push_back(mk(1,0,0,27'h800,0,1,0,0, 0,0,0,0,27'h800));
    // Read miss at 0x900, data five cycles after acceptance.
    tbl.push_back(mk(1,1,0,27'h900,0,1,0,0, 1,0,0,0,27'h800));
    tbl.push_back(mk(1,1,0,27'h900,0,0,0,0, 1,1,0,0,27'h900));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1,1,0,27'h900,0,1,0,0, 1,0,0,0,27'h900));
    tbl.push_back(mk(1,1,0,27'h900,0,1,1,32'hCAFE_0001, 1,0,0,0,27'h900));
    tbl.push_back(mk(1,1,0,27'h900,0,1,0,0, 0,0,0,32'hCAFE_0001,27'h900));
    // Read held 20 more cycles: served from the hit register.
    for (int i = 0; i < 20; i++) tbl.push_back(mk(1,1,0,27'h900,0,1,0,0, 0,0,0,32'hCAFE_0001,27'h900));
    // Write-through to the cached word, then hit on the new data.
    tbl.push_back(mk(1,0,1,27'h900,32'hAAAA_5555,1,0,0, 1,0,0,32'hCAFE_0001,27'h900));
    tbl.push_back(mk(1,0,1,27'h900,32'hAAAA_5555,0,0,0, 1,0,1,32'hCAFE_0001,27'h900));
    tbl.push_back(mk(1,0,0,27'h900,0,1,0,0, 0,0,0,32'hCAFE_0001,27'h900));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(1,1,0,27'h900,0,1,0,0, 0,0,0,32'hAAAA_5555,27'h900));

    foreach (tbl[i]) begin
      avl_ready = tbl[i].ready; read_req = tbl[i].rd; write_req = tbl[i].wr;
      address = tbl[i].addr; write_data = tbl[i].wdata; avl_waitrequest = tbl[i].wreq;
      avl_readdatavalid = tbl[i].rdv; avl_readdata = tbl[i].rdin;
      #1;
      n_vec++;
      if (stall !== tbl[i].stall || avl_read !== tbl[i].aread || avl_write !== tbl[i].awrite ||
          read_data !== tbl[i].rdata || avl_address !== tbl[i].aaddr ||
          (avl_write && avl_writedata !== tbl[i].wdata)) begin
        n_bad++;
        $display("FAIL vec%0d: got stall=%b rd=%b wr=%b data=%h aaddr=%h wdata=%h expected stall=%b rd=%b wr=%b data=%h aaddr=%h",
                 i, stall, avl_read, avl_write, read_data, avl_address, avl_writedata,
                 tbl[i].stall, tbl[i].aread, tbl[i].awrite, tbl[i].rdata, tbl[i].aaddr);
      end
      @(posedge clk); #1;
    end

    // Timeout: read miss that never returns data.
    read_req = 1'b1; write_req = 1'b0; address = 27'hA00;
    avl_waitrequest = 1'b0; avl_readdatavalid = 1'b0;
    #1;
    chk("to_idle_miss_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    n = 0;
    while (stall && !err && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    chk("to_wait_cycles", n, 32'd15);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_stall_done", {31'd0, stall}, 32'd0);
    chk("to_read_data", read_data, 32'hDEAD_BEEF);
    chk("to_strobe_off", {31'd0, avl_read}, 32'd0);
    @(posedge clk); #1;
    chk("to_stall_again", {31'd0, stall}, 32'd1);
    chk("to_err_sticky", {31'd0, err}, 32'd1);

    // Reset in RDW, followed by a stale readdatavalid.
    @(posedge clk); #1;
    chk("rr_rd_strobe", {31'd0, avl_read}, 32'd1);
    chk("rr_rd_addr", {5'd0, avl_address}, 32'hA00);
    @(posedge clk); #1;
    chk("rr_rdw_strobe", {31'd0, avl_read}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; avl_ready = 1'b0; read_req = 1'b0;
    avl_readdatavalid = 1'b1; avl_readdata = 32'h0BAD_0BAD;
    #1;
    chk("rr_stall_init", {31'd0, stall}, 32'd1);
    chk("rr_err_clear", {31'd0, err}, 32'd0);
    chk("rr_strobe", {31'd0, avl_read}, 32'd0);
    @(posedge clk); #1;
    avl_readdatavalid = 1'b0;
    chk("rr_stale_ignored", read_data, 32'd0);
    avl_ready = 1'b1;
    @(posedge clk); #1;
    read_req = 1'b1; address = 27'h900;
    #1;
    chk("rr_hit_invalid", {31'd0, stall}, 32'd1);
    chk("rr_read_data", read_data, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
